// File: rtl/id_ex_skid_reg.sv
`default_nettype none
// id_ex_skid_reg -- ID/EX pipeline register with a skid slot so in_ready comes straight from a flop. Rev 1.0
// Define ID_EX_FWD_EN to forward write-back data into captured and held operands.
module id_ex_skid_reg #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int ALUF_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              RegWriteC,
    input  logic              MemWriteC,
    input  logic              MemToRegC,
    input  logic [ALUF_W-1:0] aluFuncC,
    input  logic [REG_AW-1:0] srcAddD1,
    input  logic [REG_AW-1:0] srcAddD2,
    input  logic [DATA_W-1:0] srcDataD1,
    input  logic [DATA_W-1:0] srcDataD2,
    input  logic [REG_AW-1:0] destAddD,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              MemToRegE,
    output logic [ALUF_W-1:0] aluFuncE,
    output logic [DATA_W-1:0] srcDataE1,
    output logic [DATA_W-1:0] srcDataE2,
    output logic [REG_AW-1:0] destAddE
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              mem_to_reg;
        logic [ALUF_W-1:0] alu_func;
        logic [REG_AW-1:0] src_add1;
        logic [REG_AW-1:0] src_add2;
        logic [DATA_W-1:0] src_data1;
        logic [DATA_W-1:0] src_data2;
        logic [REG_AW-1:0] dest_add;
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d;
    entry_t in_raw, in_ent, main_cur, skid_cur;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept, drain;

    assign in_raw = {RegWriteC, MemWriteC, MemToRegC, aluFuncC, srcAddD1, srcAddD2,
                     srcDataD1, srcDataD2, destAddD};

`ifdef ID_EX_FWD_EN
    function automatic entry_t fwd(input entry_t e, input logic we,
                                   input logic [REG_AW-1:0] addr, input logic [DATA_W-1:0] data);
        entry_t r;
        r = e;
        if (we && (e.src_add1 == addr)) r.src_data1 = data;
        if (we && (e.src_add2 == addr)) r.src_data2 = data;
        return r;
    endfunction

    assign in_ent   = fwd(in_raw, wb_we, wb_addr, wb_data);
    assign main_cur = fwd(main_q, wb_we, wb_addr, wb_data);
    assign skid_cur = fwd(skid_q, wb_we, wb_addr, wb_data);
`else
    logic unused_fwd;

    assign in_ent   = in_raw;
    assign main_cur = main_q;
    assign skid_cur = skid_q;
    // Source addresses and write-back inputs only matter to the forwarding build.
    assign unused_fwd = ^{wb_we, wb_addr, wb_data, main_q.src_add1, main_q.src_add2,
                          skid_q.src_add1, skid_q.src_add2};
`endif

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign accept    = in_valid & in_ready;
    assign drain     = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_cur;
        skid_d       = skid_cur;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            main_d       = skid_cur;
            skid_valid_d = 1'b0;
        end else if (accept && (!main_valid_q || drain)) begin
            main_d       = in_ent;
            main_valid_d = 1'b1;
        end else if (accept) begin
            skid_d       = in_ent;
            skid_valid_d = 1'b1;
        end else if (drain) begin
            main_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    // Stale payload may sit in main after a drain; gating the control bits keeps bubbles harmless.
    assign RegWriteE = main_q.reg_write  & main_valid_q;
    assign MemWriteE = main_q.mem_write  & main_valid_q;
    assign MemToRegE = main_q.mem_to_reg & main_valid_q;
    assign aluFuncE  = main_q.alu_func;
    assign srcDataE1 = main_q.src_data1;
    assign srcDataE2 = main_q.src_data2;
    assign destAddE  = main_q.dest_add;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_reg.sv
`default_nettype none
// tb_id_ex_skid_reg -- scoreboard bench for id_ex_skid_reg against an in-order queue model.
module tb_id_ex_skid_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        RegWriteC = 1'b0, MemWriteC = 1'b0, MemToRegC = 1'b0;
    logic [1:0]  aluFuncC = '0;
    logic [3:0]  srcAddD1 = '0, srcAddD2 = '0, destAddD = '0;
    logic [15:0] srcDataD1 = '0, srcDataD2 = '0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        RegWriteE, MemWriteE, MemToRegE;
    logic [1:0]  aluFuncE;
    logic [15:0] srcDataE1, srcDataE2;
    logic [3:0]  destAddE;

    id_ex_skid_reg #(.DATA_W(16), .REG_AW(4), .ALUF_W(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .RegWriteC(RegWriteC), .MemWriteC(MemWriteC), .MemToRegC(MemToRegC),
        .aluFuncC(aluFuncC), .srcAddD1(srcAddD1), .srcAddD2(srcAddD2),
        .srcDataD1(srcDataD1), .srcDataD2(srcDataD2), .destAddD(destAddD),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE),
        .aluFuncE(aluFuncE), .srcDataE1(srcDataE1), .srcDataE2(srcDataE2),
        .destAddE(destAddE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mw, mtr;
        logic [1:0]  af;
        logic [3:0]  a1, a2;
        logic [15:0] d1, d2;
        logic [3:0]  dst;
    } exp_t;

    exp_t q[$];
    int   pre_sz = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [40:0] w_out;
    assign w_out = {RegWriteE, MemWriteE, MemToRegE, aluFuncE, srcDataE1, srcDataE2, destAddE};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [40:0] exp_out(input exp_t e);
        return {e.rw, e.mw, e.mtr, e.af, e.d1, e.d2, e.dst};
    endfunction

    // Instruction as it should be captured: operand replaced by a matching write-back when forwarding is built in.
    function automatic exp_t cur_in();
        exp_t e;
        e = {RegWriteC, MemWriteC, MemToRegC, aluFuncC, srcAddD1, srcAddD2, srcDataD1, srcDataD2, destAddD};
`ifdef ID_EX_FWD_EN
        if (wb_we && wb_addr == e.a1) e.d1 = wb_data;
        if (wb_we && wb_addr == e.a2) e.d2 = wb_data;
`endif
        return e;
    endfunction

    // Monitor: compares the head of the queue with what the DUT presents, pops on consumption.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            pre_sz = 0;
        end else begin
            pre_sz = q.size();
            chk("out_valid", {63'd0, out_valid}, {63'd0, pre_sz != 0});
            chk("in_ready", {63'd0, in_ready}, {63'd0, pre_sz != 2});
            if (pre_sz != 0) begin
                chk("payload", {23'd0, w_out}, {23'd0, exp_out(q[0])});
                if (out_ready) void'(q.pop_front());
            end else begin
                chk("bubble_ctrl", {61'd0, RegWriteE, MemWriteE, MemToRegE}, 64'd0);
            end
        end
    end

    // Model: applies this cycle's flush/write-back/accept to the expected queue.
    initial forever begin
        @(negedge clk);
        #1;
        if (!reset || flush) begin
            q.delete();
        end else begin
`ifdef ID_EX_FWD_EN
            if (wb_we) begin
                foreach (q[i]) begin
                    exp_t e;
                    e = q[i];
                    if (e.a1 == wb_addr) e.d1 = wb_data;
                    if (e.a2 == wb_addr) e.d2 = wb_data;
                    q[i] = e;
                end
            end
`endif
            if (in_valid && pre_sz != 2) q.push_back(cur_in());
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
        RegWriteC = 1'b0; MemWriteC = 1'b0; MemToRegC = 1'b0; aluFuncC = '0;
        srcAddD1 = '0; srcAddD2 = '0; srcDataD1 = '0; srcDataD2 = '0; destAddD = '0;
        wb_addr = '0; wb_data = '0;
    endtask

    task automatic beat(input logic [15:0] d1, input logic mw);
        clear_in();
        in_valid = 1'b1; srcDataD1 = d1; MemWriteC = mw; destAddD = d1[3:0];
    endtask

    initial begin
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_outputs", {23'd0, w_out}, 64'd0);
        nxt(); nxt();
        reset = 1'b1;

        // single beat, one-cycle latency, then bubble
        nxt(); beat(16'h1234, 1'b0); destAddD = 4'h3; RegWriteC = 1'b1; out_ready = 1'b1;
        nxt(); clear_in();
        chk("beat_valid", {63'd0, out_valid}, 64'd1);
        chk("beat_data1", {48'd0, srcDataE1}, 64'h1234);
        chk("beat_regwr", {63'd0, RegWriteE}, 64'd1);
        nxt();
        chk("bubble_valid", {63'd0, out_valid}, 64'd0);
        chk("bubble_regwr", {63'd0, RegWriteE}, 64'd0);

        // stall fills main and skid, then drains in order
        out_ready = 1'b0; beat(16'h0001, 1'b0);
        nxt(); beat(16'h0002, 1'b0);
        nxt(); clear_in();
        chk("skid_full_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_head", {48'd0, srcDataE1}, 64'h0001);
        nxt(); out_ready = 1'b1;
        nxt();
        chk("drain_second", {48'd0, srcDataE1}, 64'h0002);
        chk("drain_ready", {63'd0, in_ready}, 64'd1);
        nxt();
        chk("drain_empty", {63'd0, out_valid}, 64'd0);

        // flush with both entries full and a live input
        out_ready = 1'b0; beat(16'h00A1, 1'b1);
        nxt(); beat(16'h00A2, 1'b1);
        nxt(); beat(16'h00A3, 1'b1); flush = 1'b1;
        nxt(); clear_in();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_memwr", {63'd0, MemWriteE}, 64'd0);
        out_ready = 1'b1; nxt(); nxt();

        // asynchronous reset mid-stream with skid full
        out_ready = 1'b0; beat(16'h00B1, 1'b1);
        nxt(); beat(16'h00B2, 1'b1);
        nxt(); clear_in();
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_outputs", {23'd0, w_out}, 64'd0);
        nxt(); reset = 1'b1; out_ready = 1'b1;

        // write-back hit on capture
        nxt(); clear_in(); in_valid = 1'b1; srcAddD1 = 4'h5; srcDataD1 = 16'h0000;
        wb_we = 1'b1; wb_addr = 4'h5; wb_data = 16'hBEEF;
        nxt(); clear_in();
`ifdef ID_EX_FWD_EN
        chk("fwd_capture", {48'd0, srcDataE1}, 64'hBEEF);
`else
        chk("fwd_capture", {48'd0, srcDataE1}, 64'h0000);
`endif

        // full throughput with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            nxt(); beat(16'(i + 16'h0100), i[0]); RegWriteC = i[1];
        end

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            nxt(); clear_in();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            RegWriteC = 1'($urandom); MemWriteC = 1'($urandom); MemToRegC = 1'($urandom);
            aluFuncC  = 2'($urandom);
            srcAddD1  = 4'($urandom_range(0, 3)); srcAddD2 = 4'($urandom_range(0, 3));
            srcDataD1 = 16'($urandom); srcDataD2 = 16'($urandom);
            destAddD  = 4'($urandom);
            wb_we     = 1'($urandom); wb_addr = 4'($urandom_range(0, 3)); wb_data = 16'($urandom);
        end

        nxt(); clear_in(); out_ready = 1'b1;
        for (int i = 0; i < 4; i++) nxt();
        chk("final_drained", {63'd0, out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
